fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter MEM_LAT, default 3: memory read latency in cycles, legal range 1..15.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value after reset.
REQ-003 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1: asynchronous, active-high reset.
REQ-005 Port fetch_req  in  1: control unit requests the next instruction fetch; level, sampled each cycle.
REQ-006 Port pc_load  in  1: control unit PCWrite; loads pc_next into PC.
REQ-007 Port pc_next  in  32: new PC value (branch/jump target or ALU result).
REQ-008 Port mem_rdata  in  32: instruction word from memory; valid MEM_LAT cycles after mem_addr is presented.
REQ-009 Port mem_addr  out  32: memory address, equal to PC.
REQ-010 Port mem_rd  out  1: memory read strobe.
REQ-011 Port instr  out  32: instruction register contents.
REQ-012 Port OPCODE  out  6: instr[31:26].
REQ-013 Port funct  out  6: instr[5:0].
REQ-014 Ports rs, rt, rd  out  5 each: instr[25:21], instr[20:16], instr[15:11].
REQ-015 Port imm16  out  16: instr[15:0].
REQ-016 Port pc  out  32: current PC.
REQ-017 Port instr_valid  out  1: instr holds a completed fetch.
REQ-018 Port busy  out  1: high in WAIT and CAPTURE.
REQ-019 Port fetch_fault  out  1: sticky flag for a misaligned fetch address.

Function
REQ-020 FSM states: IDLE, WAIT, CAPTURE, VALID, FAULT.
REQ-021 IDLE or VALID with fetch_req=1 and pc[1:0]==0: go to WAIT; clear counter; drop instr_valid; assert mem_rd.
REQ-022 IDLE or VALID with fetch_req=1 and pc[1:0]!=0: go to FAULT; set fetch_fault; never assert mem_rd.
REQ-023 WAIT: mem_rd=1; mem_addr held stable; counter increments each cycle; at counter==MEM_LAT-1, go to CAPTURE.
REQ-024 CAPTURE: instr<=mem_rdata; PC<=PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0); go to VALID.
REQ-025 Latency: fetch_req sampled -> instr_valid high exactly MEM_LAT+2 cycles later (5 at default).
REQ-026 VALID: instr_valid=1; instr is held until the next accepted fetch_req.
REQ-027 pc_load in IDLE, VALID or FAULT: PC<=pc_next on the next edge.
REQ-028 pc_load in WAIT: store pc_next in a pending register; mem_addr is unchanged.
REQ-029 CAPTURE with a pending load: PC<=pending value, not PC+4; then clear pending.
REQ-030 pc_load in CAPTURE: pc_next wins over PC+4 and over any pending value.
REQ-031 fetch_req and pc_load asserted together in IDLE/VALID: the fetch uses the old PC; the load becomes pending.
REQ-032 FAULT: stays until pc_load with pc_next[1:0]==0, then returns to IDLE; fetch_fault clears on that transition.
REQ-033 fetch_req while busy is ignored and is not queued.
REQ-034 OPCODE, funct, rs, rt, rd and imm16 are combinational slices of instr.

Reset
REQ-035 Reset asserted: PC=RESET_PC, instr=0, instr_valid=0, mem_rd=0, busy=0, fetch_fault=0, counter=0, pending cleared, state=IDLE.
REQ-036 Reset takes effect immediately, including mid-WAIT; the in-flight fetch is abandoned and memory data is not captured.
REQ-037 After reset deassertion the first fetch_req is accepted on the first rising edge.

Structure
REQ-038 Shared package holds the FSM state encoding, RESET_PC default, MEM_LAT default and the OPCODE/funct field position constants.
REQ-039 One sub-module, instr_fields: a purely combinational splitter of instr into its fields.

Verification
REQ-040 Reset, then fetch_req=1 for 1 cycle, mem_rdata=32'h0123_4020 -> instr_valid at cycle 5; OPCODE=0, funct=32, pc=4.
REQ-041 pc_load=1 with pc_next=32'h100 during WAIT cycle 2 -> mem_addr stays 0 through WAIT; after CAPTURE pc=32'h100, not 4.
REQ-042 pc_load with pc_next=32'h102, then fetch_req -> FAULT, fetch_fault=1, mem_rd never high; pc_load 32'h104 -> IDLE, fetch_fault=0.
REQ-043 PC=32'hFFFF_FFFC, one fetch -> pc=0 after CAPTURE, instr captured correctly.
REQ-044 Reset asserted asynchronously mid-WAIT -> all outputs at reset values before the next edge; instr=0.
REQ-045 Build with MEM_LAT=1, back-to-back fetch_req held high -> instr_valid pulses every 3 cycles; pc advances by 4 per fetch.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, defaults,
// FSM encoding and instruction field positions.
package fetch_unit_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned MEM_LAT_DEFAULT = 3;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned FUNCT_W    = 6;
    localparam int unsigned IMM_LSB    = 0;
    localparam int unsigned IMM_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_VALID   = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [FUNCT_W-1:0]  funct;
        logic [IMM_W-1:0]    imm16;
    } instr_fields_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read port between the fetch unit and memory.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic [XLEN-1:0] mem_addr;
    logic            mem_rd;
    logic [XLEN-1:0] mem_rdata;

    modport master (output mem_addr, output mem_rd, input mem_rdata);
    modport slave  (input mem_addr, input mem_rd, output mem_rdata);

endinterface

// File: rtl/instr_fields.sv
// Purely combinational splitter of an instruction word into its fields.
module instr_fields
    import fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output instr_fields_t   fields
);

    assign fields.opcode = instr[OPCODE_LSB +: OPCODE_W];
    assign fields.rs     = instr[RS_LSB +: REG_W];
    assign fields.rt     = instr[RT_LSB +: REG_W];
    assign fields.rd     = instr[RD_LSB +: REG_W];
    assign fields.funct  = instr[FUNCT_LSB +: FUNCT_W];
    assign fields.imm16  = instr[IMM_LSB +: IMM_W];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, fixed-latency memory read, instruction register
// and misaligned-fetch fault handling.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     MEM_LAT  = MEM_LAT_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_req,
    input  logic                pc_load,
    input  logic [XLEN-1:0]     pc_next,
    fetch_unit_if.master        mem,
    output logic [XLEN-1:0]     instr,
    output logic [OPCODE_W-1:0] OPCODE,
    output logic [FUNCT_W-1:0]  funct,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [REG_W-1:0]    rd,
    output logic [IMM_W-1:0]    imm16,
    output logic [XLEN-1:0]     pc,
    output logic                instr_valid,
    output logic                busy,
    output logic                fetch_fault
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;
    logic            mem_rd_q, mem_rd_d;
    logic            busy_q, busy_d;
    instr_fields_t   fields;

    wire pc_aligned   = (pc_q[1:0] == 2'b00);
    wire next_aligned = (pc_next[1:0] == 2'b00);
    wire wait_done    = (cnt_q == CNT_W'(MEM_LAT - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_VALID: begin
                if (fetch_req) state_d = pc_aligned ? ST_WAIT : ST_FAULT;
            end
            ST_WAIT:    if (wait_done) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_VALID;
            ST_FAULT:   if (pc_load && next_aligned) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pend_pc_d  = pend_pc_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        mem_rd_d   = (state_d == ST_WAIT);
        busy_d     = (state_d == ST_WAIT) || (state_d == ST_CAPTURE);
        case (state_q)
            ST_IDLE, ST_VALID: begin
                if (fetch_req && pc_aligned) begin
                    // The fetch uses the current PC, so a coincident load waits.
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    if (pc_load) begin
                        pend_vld_d = 1'b1;
                        pend_pc_d  = pc_next;
                    end
                end else begin
                    if (fetch_req) begin
                        fault_d = 1'b1;
                        valid_d = 1'b0;
                    end
                    if (pc_load) pc_d = pc_next;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (pc_load) begin
                    pend_vld_d = 1'b1;
                    pend_pc_d  = pc_next;
                end
            end
            ST_CAPTURE: begin
                instr_d    = mem.mem_rdata;
                valid_d    = 1'b1;
                pend_vld_d = 1'b0;
                if (pc_load)         pc_d = pc_next;
                else if (pend_vld_q) pc_d = pend_pc_q;
                else                 pc_d = pc_q + 32'd4;
            end
            ST_FAULT: begin
                if (pc_load) pc_d = pc_next;
                if (pc_load && next_aligned) fault_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pend_pc_q  <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            mem_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pend_pc_q  <= pend_pc_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            mem_rd_q   <= mem_rd_d;
            busy_q     <= busy_d;
        end
    end

    instr_fields u_fields (
        .instr  (instr_q),
        .fields (fields)
    );

    assign mem.mem_addr = pc_q;
    assign mem.mem_rd   = mem_rd_q;
    assign pc           = pc_q;
    assign instr        = instr_q;
    assign instr_valid  = valid_q;
    assign busy         = busy_q;
    assign fetch_fault  = fault_q;
    assign OPCODE       = fields.opcode;
    assign funct        = fields.funct;
    assign rs           = fields.rs;
    assign rt           = fields.rt;
    assign rd           = fields.rd;
    assign imm16        = fields.imm16;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_fetch_unit;

    localparam int unsigned LAT0 = 3;
    localparam int unsigned LAT1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Memory contents: addr 0 holds add-like word, others are derived from addr.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0123_4020 : (a ^ 32'h8C00_0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // DUT 0: default latency
    logic rst0 = 1'b1, req0 = 1'b0, ld0 = 1'b0;
    logic [31:0] nxt0 = '0;
    logic [31:0] instr0, pc0;
    logic [5:0]  op0, fn0;
    logic [4:0]  rs0, rt0, rd0;
    logic [15:0] imm0;
    logic        valid0, busy0, fault0;
    fetch_unit_if bus0 ();

    fetch_unit #(.MEM_LAT(LAT0)) u0 (
        .clk(clk), .reset(rst0), .fetch_req(req0), .pc_load(ld0), .pc_next(nxt0),
        .mem(bus0.master), .instr(instr0), .OPCODE(op0), .funct(fn0),
        .rs(rs0), .rt(rt0), .rd(rd0), .imm16(imm0), .pc(pc0),
        .instr_valid(valid0), .busy(busy0), .fetch_fault(fault0)
    );

    // DUT 1: single-cycle latency
    logic rst1 = 1'b1, req1 = 1'b0, ld1 = 1'b0;
    logic [31:0] nxt1 = '0;
    logic [31:0] instr1, pc1;
    logic [5:0]  op1, fn1;
    logic [4:0]  rs1, rt1, rd1;
    logic [15:0] imm1;
    logic        valid1, busy1, fault1;
    fetch_unit_if bus1 ();

    fetch_unit #(.MEM_LAT(LAT1)) u1 (
        .clk(clk), .reset(rst1), .fetch_req(req1), .pc_load(ld1), .pc_next(nxt1),
        .mem(bus1.master), .instr(instr1), .OPCODE(op1), .funct(fn1),
        .rs(rs1), .rt(rt1), .rd(rd1), .imm16(imm1), .pc(pc1),
        .instr_valid(valid1), .busy(busy1), .fetch_fault(fault1)
    );

    // Memories: data for a read seen in cycle c appears in cycle c+LAT.
    logic [32:0] hist0 [LAT0];
    logic [32:0] hist1 [LAT1];
    always @(posedge clk) begin
        hist0[0] <= {bus0.mem_rd, bus0.mem_addr};
        for (int i = 1; i < int'(LAT0); i++) hist0[i] <= hist0[i-1];
        hist1[0] <= {bus1.mem_rd, bus1.mem_addr};
    end
    assign bus0.mem_rdata = hist0[LAT0-1][32] ? mem_word(hist0[LAT0-1][31:0]) : 32'hDEAD_BEEF;
    assign bus1.mem_rdata = hist1[LAT1-1][32] ? mem_word(hist1[LAT1-1][31:0]) : 32'hDEAD_BEEF;

    // Reference model: a fetch is a countdown of remaining busy cycles.
    int          m_left;
    logic [31:0] m_pc, m_instr, m_faddr, m_pend_pc;
    logic        m_valid, m_fault, m_pend;

    task automatic model_reset();
        m_left = 0; m_pc = 32'h0; m_instr = 32'h0; m_faddr = 32'h0;
        m_pend_pc = 32'h0; m_valid = 1'b0; m_fault = 1'b0; m_pend = 1'b0;
    endtask

    task automatic model_edge(input logic req, input logic ld, input logic [31:0] nxt);
        if (m_left == 1) begin
            m_instr = mem_word(m_faddr);
            m_valid = 1'b1;
            m_pc    = ld ? nxt : (m_pend ? m_pend_pc : m_pc + 32'd4);
            m_pend  = 1'b0;
            m_left  = 0;
        end else if (m_left > 1) begin
            if (ld) begin m_pend = 1'b1; m_pend_pc = nxt; end
            m_left--;
        end else if (m_fault) begin
            if (ld) m_pc = nxt;
            if (ld && nxt[1:0] == 2'b00) m_fault = 1'b0;
        end else if (req && m_pc[1:0] == 2'b00) begin
            m_faddr = m_pc;
            m_left  = int'(LAT0) + 1;
            m_valid = 1'b0;
            if (ld) begin m_pend = 1'b1; m_pend_pc = nxt; end
        end else begin
            if (req) begin m_fault = 1'b1; m_valid = 1'b0; end
            if (ld) m_pc = nxt;
        end
    endtask

    task automatic model_cmp(input string tag);
        chk({tag, ".pc"},       pc0,                 m_pc);
        chk({tag, ".mem_addr"}, bus0.mem_addr,       m_pc);
        chk({tag, ".mem_rd"},   32'(bus0.mem_rd),    32'(m_left > 1));
        chk({tag, ".busy"},     32'(busy0),          32'(m_left > 0));
        chk({tag, ".valid"},    32'(valid0),         32'(m_valid));
        chk({tag, ".fault"},    32'(fault0),         32'(m_fault));
        chk({tag, ".instr"},    instr0,              m_instr);
    endtask

    task automatic step0(input string tag, input logic req, input logic ld, input logic [31:0] nxt);
        req0 = req; ld0 = ld; nxt0 = nxt;
        @(posedge clk);
        model_edge(req, ld, nxt);
        #1;
        model_cmp(tag);
    endtask

    task automatic reset0();
        rst0 = 1'b1; req0 = 1'b0; ld0 = 1'b0;
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        model_reset();
    endtask

    typedef struct packed {
        logic        rst, req, ld;
        logic [31:0] nxt;
        logic        e_busy, e_rd, e_valid, e_fault;
        logic [31:0] e_pc, e_instr;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [31:0] r, nx;
        logic        rq, lq;

        // Row inputs apply before an edge; expectations are sampled 1ns after it.
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 32'h4,   32'h0123_4020};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0123_4020};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h102, 1'b0, 1'b0, 1'b1, 1'b0, 32'h102, 32'h0123_4020};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 32'h102, 32'h0123_4020};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 32'h102, 32'h0123_4020};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 32'h0123_4020};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h104, 32'h0123_4020};

        // Reset values on both instances
        repeat (2) @(posedge clk);
        #1;
        chk("rst.pc0", pc0, 32'h0);
        chk("rst.instr0", instr0, 32'h0);
        chk("rst.flags0", {28'h0, valid0, busy0, fault0, bus0.mem_rd}, 32'h0);
        chk("rst.flags1", {28'h0, valid1, busy1, fault1, bus1.mem_rd}, 32'h0);
        rst0 = 1'b0;

        for (int i = 0; i < 16; i++) begin
            rst0 = vecs[i].rst; req0 = vecs[i].req; ld0 = vecs[i].ld; nxt0 = vecs[i].nxt;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.busy", i),   32'(busy0),        32'(vecs[i].e_busy));
            chk($sformatf("vec%0d.mem_rd", i), 32'(bus0.mem_rd),  32'(vecs[i].e_rd));
            chk($sformatf("vec%0d.valid", i),  32'(valid0),       32'(vecs[i].e_valid));
            chk($sformatf("vec%0d.fault", i),  32'(fault0),       32'(vecs[i].e_fault));
            chk($sformatf("vec%0d.pc", i),     pc0,               vecs[i].e_pc);
            chk($sformatf("vec%0d.addr", i),   bus0.mem_addr,     vecs[i].e_pc);
            chk($sformatf("vec%0d.instr", i),  instr0,            vecs[i].e_instr);
            chk($sformatf("vec%0d.opcode", i), 32'(op0),          32'(vecs[i].e_instr[31:26]));
            chk($sformatf("vec%0d.funct", i),  32'(fn0),          32'(vecs[i].e_instr[5:0]));
            chk($sformatf("vec%0d.regs", i),   32'({rs0, rt0, rd0}), 32'(vecs[i].e_instr[25:11]));
            chk($sformatf("vec%0d.imm16", i),  32'(imm0),         32'(vecs[i].e_instr[15:0]));
        end
        req0 = 1'b0;
        chk("fields.opcode_add", 32'(op0), 32'h0);
        chk("fields.funct_add", 32'(fn0), 32'd32);

        // PC wrap at the top of the address space
        reset0();
        step0("wrap.load", 1'b0, 1'b1, 32'hFFFF_FFFC);
        step0("wrap.req", 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < int'(LAT0) + 1; i++) step0("wrap.run", 1'b0, 1'b0, 32'h0);
        chk("wrap.pc", pc0, 32'h0);
        chk("wrap.instr", instr0, 32'h73FF_FFFC);
        chk("wrap.valid", 32'(valid0), 32'h1);

        // Asynchronous reset in the middle of WAIT
        req0 = 1'b1;
        @(posedge clk); #1; req0 = 1'b0;
        @(posedge clk); #3;
        rst0 = 1'b1;
        #1;
        chk("arst.pc", pc0, 32'h0);
        chk("arst.instr", instr0, 32'h0);
        chk("arst.flags", {28'h0, valid0, busy0, fault0, bus0.mem_rd}, 32'h0);
        @(posedge clk); #1;
        rst0 = 1'b0;
        repeat (int'(LAT0) + 2) @(posedge clk);
        #1;
        chk("arst.no_capture", instr0, 32'h0);
        chk("arst.idle", {29'h0, valid0, busy0, bus0.mem_rd}, 32'h0);

        // Randomized traffic against the model
        reset0();
        for (int n = 0; n < 600; n++) begin
            rq = ($urandom_range(0, 2) != 0);
            lq = ($urandom_range(0, 5) == 0);
            r  = 32'($urandom_range(0, 15));
            if (r == 0)      nx = 32'hFFFF_FFFC;
            else if (r == 1) nx = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
            else             nx = 32'($urandom_range(0, 255)) << 2;
            step0($sformatf("rand%0d", n), rq, lq, nx);
        end
        req0 = 1'b0; ld0 = 1'b0;

        // Single-cycle latency, fetch_req held high: a result every 3 cycles
        rst1 = 1'b0; req1 = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            chk($sformatf("lat1.valid%0d", n), 32'(valid1), 32'(n % 3 == 0));
            chk($sformatf("lat1.mem_rd%0d", n), 32'(bus1.mem_rd), 32'(n % 3 == 1));
            chk($sformatf("lat1.pc%0d", n), pc1, 32'(4 * (n / 3)));
            if (n % 3 == 0)
                chk($sformatf("lat1.instr%0d", n), instr1, mem_word(32'(4 * (n / 3 - 1))));
        end
        req1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
